// File: rtl/controle_leds_pkg.sv
// Shared state encodings and LED patterns for the memory-game LED controller.
package controle_leds_pkg;

    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        MEMORIA     = 3'd1,
        ECO         = 3'd2,
        RES_ACESO   = 3'd3,
        RES_APAGADO = 3'd4
    } estado_t;

    localparam logic [3:0] PADRAO_ACERTO_ON  = 4'b1111;
    localparam logic [3:0] PADRAO_ACERTO_OFF = 4'b0000;
    localparam logic [3:0] PADRAO_ERRO_A     = 4'b1010;
    localparam logic [3:0] PADRAO_ERRO_B     = 4'b0101;

    // Result pattern for the current blink phase (aceso = first half-period).
    function automatic logic [3:0] padrao_resultado(input logic venceu, input logic aceso);
        if (venceu)
            return aceso ? PADRAO_ACERTO_ON : PADRAO_ACERTO_OFF;
        else
            return aceso ? PADRAO_ERRO_A : PADRAO_ERRO_B;
    endfunction

endpackage

// File: rtl/contador_tempo.sv
// Cycle timer: counts while conta=1, flags fim on its terminal value M-1 and
// wraps there, so the count never exceeds M-1. zera has priority over conta.
module contador_tempo #(
    parameter int M = 500,
    parameter int W = (M > 1) ? $clog2(M) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    logic [W-1:0] r_contagem;

    assign fim = (r_contagem == W'(M - 1));

    // Count register: clear, hold or advance with wrap at the terminal value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_contagem <= '0;
        else if (zera)
            r_contagem <= '0;
        else if (conta)
            r_contagem <= fim ? '0 : r_contagem + W'(1);
    end

endmodule

// File: rtl/controle_leds_jogo.sv
// LED arbiter for the memory game: memory display, button echo with hold time
// and blinking result indication, with fixed priority limpa > result > memory > press.
module controle_leds_jogo
    import controle_leds_pkg::*;
#(
    parameter int ECHO_CYCLES  = 500,
    parameter int BLINK_CYCLES = 250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       limpa,
    input  logic       mostra_mem,
    input  logic [3:0] leds_mem,
    input  logic       jogada_pulso,
    input  logic [3:0] botoes,
    input  logic       acertou,
    input  logic       errou,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic [2:0] db_estado
);

    localparam int TMR_MAX = (ECHO_CYCLES > BLINK_CYCLES) ? ECHO_CYCLES : BLINK_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    estado_t    r_estado, w_prox_estado;
    logic [3:0] r_leds, w_prox_leds;
    logic [3:0] r_eco, w_prox_eco;
    logic       r_venceu, w_prox_venceu;

    logic w_resultado, w_em_res;
    logic w_fim_eco, w_conta_eco, w_zera_eco;
    logic w_fim_pisca, w_conta_pisca, w_zera_pisca;

    assign w_resultado = acertou | errou;
    assign w_em_res    = (r_estado == RES_ACESO) || (r_estado == RES_APAGADO);

    // The timers only run while the FSM stays in the same timed state; any entry,
    // exit, retrigger or limpa shows up as a state change or a press and clears them.
    assign w_conta_eco   = (r_estado == ECO) && (w_prox_estado == ECO) && !jogada_pulso;
    assign w_zera_eco    = !w_conta_eco;
    assign w_conta_pisca = w_em_res && (w_prox_estado == r_estado);
    assign w_zera_pisca  = !w_conta_pisca;

    contador_tempo #(.M(ECHO_CYCLES), .W(TMR_W)) u_tempo_eco (
        .clock (clock),
        .reset (reset),
        .zera  (w_zera_eco),
        .conta (w_conta_eco),
        .fim   (w_fim_eco)
    );

    contador_tempo #(.M(BLINK_CYCLES), .W(TMR_W)) u_tempo_pisca (
        .clock (clock),
        .reset (reset),
        .zera  (w_zera_pisca),
        .conta (w_conta_pisca),
        .fim   (w_fim_pisca)
    );

    // State, LED, echo and result-flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= OCIOSO;
            r_leds   <= '0;
            r_eco    <= '0;
            r_venceu <= 1'b0;
        end else begin
            r_estado <= w_prox_estado;
            r_leds   <= w_prox_leds;
            r_eco    <= w_prox_eco;
            r_venceu <= w_prox_venceu;
        end
    end

    // Next state by priority, then the LED value implied by the next state.
    always_comb begin
        w_prox_estado = r_estado;
        w_prox_eco    = r_eco;
        w_prox_venceu = r_venceu;
        w_prox_leds   = '0;

        if (limpa) begin
            w_prox_estado = OCIOSO;
            w_prox_eco    = '0;
        end else if (w_resultado && !w_em_res) begin
            w_prox_estado = RES_ACESO;
            w_prox_venceu = acertou & ~errou;
        end else begin
            unique case (r_estado)
                OCIOSO: begin
                    if (mostra_mem) begin
                        w_prox_estado = MEMORIA;
                    end else if (jogada_pulso) begin
                        w_prox_estado = ECO;
                        w_prox_eco    = botoes;
                    end
                end
                MEMORIA: begin
                    if (!mostra_mem)
                        w_prox_estado = OCIOSO;
                end
                ECO: begin
                    if (mostra_mem) begin
                        w_prox_estado = MEMORIA;
                        w_prox_eco    = '0;
                    end else if (jogada_pulso) begin
                        w_prox_eco = botoes;
                    end else if (w_fim_eco) begin
                        w_prox_estado = OCIOSO;
                    end
                end
                RES_ACESO: begin
                    if (!w_resultado)
                        w_prox_estado = OCIOSO;
                    else if (w_fim_pisca)
                        w_prox_estado = RES_APAGADO;
                end
                RES_APAGADO: begin
                    if (!w_resultado)
                        w_prox_estado = OCIOSO;
                    else if (w_fim_pisca)
                        w_prox_estado = RES_ACESO;
                end
                default: w_prox_estado = OCIOSO;
            endcase
        end

        unique case (w_prox_estado)
            MEMORIA:     w_prox_leds = leds_mem;
            ECO:         w_prox_leds = w_prox_eco;
            RES_ACESO:   w_prox_leds = padrao_resultado(w_prox_venceu, 1'b1);
            RES_APAGADO: w_prox_leds = padrao_resultado(w_prox_venceu, 1'b0);
            default:     w_prox_leds = '0;
        endcase
    end

    assign leds      = r_leds;
    assign ocupado   = (r_estado != OCIOSO);
    assign db_estado = r_estado;

endmodule
